// File: rtl/swin_bram_pkg.sv
// Shared defaults and types for the sliding-window BRAM stream path.
package swin_bram_pkg;

    localparam int unsigned DefMemAddrWidth = 9;
    localparam int unsigned DefMemWordWidth = 64;
    localparam int unsigned DefRdLatency    = 2;
    localparam int unsigned DefDepth        = 2 ** DefMemAddrWidth;

    typedef logic [DefMemWordWidth-1:0] word_t;
    typedef logic [DefMemAddrWidth-1:0] addr_t;

endpackage

// File: rtl/sdp_skid_fifo.sv
// Small registered FIFO that catches words returning from the RAM read pipeline.
module sdp_skid_fifo #(
    parameter int unsigned Depth = 3,
    parameter int unsigned Width = 64,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (cnt_q == CntW'(Depth));
    assign empty_o    = (cnt_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rptr_q];
    assign count_o    = cnt_q;

    always_comb begin
        wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_ok ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sdp_ram_fifo_ctrl.sv
// Stream FIFO controller driving sdp_ram as a circular buffer, with a skid buffer for read latency.
// Define SDP_FIFO_BYPASS_EN to let words skip the RAM while the FIFO is drained.
module sdp_ram_fifo_ctrl
    import swin_bram_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = DefMemAddrWidth,
    parameter int unsigned MEM_WORD_WIDTH = DefMemWordWidth,
    parameter int unsigned RD_LATENCY     = DefRdLatency
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MEM_WORD_WIDTH-1:0]   s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [MEM_WORD_WIDTH-1:0]   m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [MEM_ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic [MEM_WORD_WIDTH-1:0]   ram_wr_data,
    output logic [MEM_WORD_WIDTH/8-1:0] ram_wr_mask,
    output logic                        ram_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0]   ram_rd_addr,
    input  logic [MEM_WORD_WIDTH-1:0]   ram_rd_data,
    output logic [MEM_ADDR_WIDTH+1:0]   level
);

    localparam int unsigned Depth     = 2 ** MEM_ADDR_WIDTH;
    localparam int unsigned CntW      = MEM_ADDR_WIDTH + 1;
    localparam int unsigned SkidDepth = RD_LATENCY + 1;
    localparam int unsigned SkidCntW  = $clog2(SkidDepth + 1);
    localparam int unsigned CreditW   = SkidCntW + 1;

    logic [MEM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           ram_cnt_q, ram_cnt_d;
    logic [RD_LATENCY-1:0]     vld_q, vld_d;
    logic [MEM_ADDR_WIDTH+1:0] level_q, level_d;
    logic [SkidCntW-1:0]       skid_cnt, inflight;
    logic [CreditW-1:0]        credit_used;
    logic [MEM_WORD_WIDTH-1:0] skid_push_data;
    logic                      skid_full, skid_empty, skid_push;
    logic                      s_fire, m_fire, wr_fire, rd_issue, bypass;

    assign s_ready = !rst && (ram_cnt_q < CntW'(Depth));
    assign s_fire  = s_valid && s_ready;
    assign m_valid = !skid_empty;
    assign m_fire  = m_valid && m_ready;

`ifdef SDP_FIFO_BYPASS_EN
    // Only safe while nothing older sits in the RAM or the read pipe.
    assign bypass = s_fire && (ram_cnt_q == '0) && (vld_q == '0) && !skid_full;
`else
    assign bypass = 1'b0;
`endif

    assign wr_fire     = s_fire && !bypass;
    assign ram_wr_en   = wr_fire;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = s_data;
    assign ram_wr_mask = '1;
    assign ram_rd_addr = rd_ptr_q;
    assign level       = level_q;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + SkidCntW'(vld_q[i]);
        end
    end

    // A pop this cycle frees a skid slot at the same edge, which keeps streaming at one word
    // per cycle; without it the skid could never hold a full pipe plus the head word.
    assign credit_used = CreditW'(inflight) + CreditW'(skid_cnt) - CreditW'(m_fire);
    assign rd_issue    = (ram_cnt_q != '0) && (credit_used < CreditW'(RD_LATENCY + 1));

    assign skid_push      = vld_q[RD_LATENCY-1] || bypass;
    assign skid_push_data = bypass ? s_data : ram_rd_data;

    always_comb begin
        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_issue ? rd_ptr_q + 1'b1 : rd_ptr_q;

        vld_d    = '0;
        vld_d[0] = rd_issue;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
        end

        ram_cnt_d = ram_cnt_q;
        case ({wr_fire, rd_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // Every accepted word is held somewhere until popped, so the level tracks the handshakes.
        level_d = level_q;
        case ({s_fire, m_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            vld_q     <= '0;
            level_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            vld_q     <= vld_d;
            level_q   <= level_d;
        end
    end

    sdp_skid_fifo #(
        .Depth (SkidDepth),
        .Width (MEM_WORD_WIDTH),
        .CntW  (SkidCntW)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (skid_push),
        .push_data_i (skid_push_data),
        .pop_i       (m_fire),
        .pop_data_o  (m_data),
        .count_o     (skid_cnt),
        .full_o      (skid_full),
        .empty_o     (skid_empty)
    );

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// Directed and table-driven checks of sdp_ram_fifo_ctrl against a behavioural sdp_ram model.
module tb_sdp_ram_fifo_ctrl;
    import swin_bram_pkg::*;

    localparam int AW  = DefMemAddrWidth;
    localparam int DW  = DefMemWordWidth;
    localparam int RDL = DefRdLatency;

    logic          clk = 1'b0;
    logic          rst, s_valid, s_ready, m_valid, m_ready, ram_wr_en;
    word_t         s_data, m_data, ram_wr_data, ram_rd_data;
    addr_t         ram_wr_addr, ram_rd_addr;
    logic [DW/8-1:0] ram_wr_mask;
    logic [AW+1:0] level;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdp_ram_fifo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_mask (ram_wr_mask),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .level       (level)
    );

    // Behavioural sdp_ram: byte-masked write, RDL-cycle registered read.
    word_t mem [2**AW];
    word_t rd_pipe [RDL];
    always @(posedge clk) begin
        if (ram_wr_en) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (ram_wr_mask[b]) mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
            end
        end
        rd_pipe[0] <= mem[ram_rd_addr];
        for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_rd_data = rd_pipe[RDL-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: inputs change on the falling edge, outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic sv, input word_t sd, input logic mr);
        @(negedge clk);
        rst     = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
    endtask

    function automatic word_t pat(input int k);
        return {32'(k), ~32'(k)};
    endfunction

    typedef struct packed {
        logic          r;
        logic          sv;
        logic [63:0]   sd;
        logic          mr;
        logic          e_sready;
        logic          e_mvalid;
        logic [63:0]   e_mdata;
        logic [10:0]   e_level;
        logic          e_wen;
        logic [8:0]    e_waddr;
        logic [8:0]    e_raddr;
    } vec_t;

    vec_t vecs [13];
    int   n, exp_w, errs, gaps, sent, rcvd, lat, lvl_err, lvl_max;
    logic sv_r, mr_r;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);

`ifndef SDP_FIFO_BYPASS_EN
        //               rst sv  data      mr  srdy mval mdata     lvl    wen waddr  raddr
        vecs[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 64'h0,  11'd0, 1'b0, 9'd0, 9'd0};
        vecs[1]  = '{1'b0, 1'b1, 64'hA0, 1'b0, 1'b1, 1'b0, 64'h0,  11'd0, 1'b1, 9'd0, 9'd0};
        vecs[2]  = '{1'b0, 1'b1, 64'hA1, 1'b0, 1'b1, 1'b0, 64'h0,  11'd1, 1'b1, 9'd1, 9'd0};
        vecs[3]  = '{1'b0, 1'b1, 64'hA2, 1'b0, 1'b1, 1'b0, 64'h0,  11'd2, 1'b1, 9'd2, 9'd1};
        vecs[4]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  11'd3, 1'b0, 9'd3, 9'd2};
        vecs[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'hA0, 11'd3, 1'b0, 9'd3, 9'd3};
        vecs[6]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA0, 11'd3, 1'b0, 9'd3, 9'd3};
        vecs[7]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA1, 11'd2, 1'b0, 9'd3, 9'd3};
        vecs[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hA2, 11'd1, 1'b0, 9'd3, 9'd3};
        vecs[9]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0,  11'd0, 1'b0, 9'd3, 9'd3};
        vecs[10] = '{1'b0, 1'b1, 64'hB0, 1'b0, 1'b1, 1'b0, 64'h0,  11'd0, 1'b1, 9'd3, 9'd3};
        vecs[11] = '{1'b1, 1'b1, 64'hB1, 1'b0, 1'b0, 1'b0, 64'h0,  11'd1, 1'b0, 9'd4, 9'd3};
        vecs[12] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  11'd0, 1'b0, 9'd0, 9'd0};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].r, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            check($sformatf("vec%0d s_ready", i), 64'(s_ready), 64'(vecs[i].e_sready));
            check($sformatf("vec%0d m_valid", i), 64'(m_valid), 64'(vecs[i].e_mvalid));
            if (vecs[i].e_mvalid) check($sformatf("vec%0d m_data", i), m_data, vecs[i].e_mdata);
            check($sformatf("vec%0d level", i), 64'(level), 64'(vecs[i].e_level));
            check($sformatf("vec%0d wr_en", i), 64'(ram_wr_en), 64'(vecs[i].e_wen));
            check($sformatf("vec%0d wr_addr", i), 64'(ram_wr_addr), 64'(vecs[i].e_waddr));
            check($sformatf("vec%0d rd_addr", i), 64'(ram_rd_addr), 64'(vecs[i].e_raddr));
        end
`else
        drive(1'b1, 1'b0, '0, 1'b0);
        check("rst s_ready", 64'(s_ready), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b0);
`endif
        check("wr_mask", 64'(ram_wr_mask), 64'hFF);

        // Fill with the consumer stalled until the controller pushes back.
        n = 0;
        for (int c = 0; c < 700; c++) begin
            drive(1'b0, 1'b1, word_t'(n), 1'b0);
            if (!s_ready) break;
            n++;
        end
        check("fill accepted", 64'(n), 64'd515);
        repeat (4) drive(1'b0, 1'b0, '0, 1'b0);
        check("fill level", 64'(level), 64'd515);
        check("fill s_ready", 64'(s_ready), 64'd0);
        check("fill m_valid", 64'(m_valid), 64'd1);

        // Pop at full: a read issues this cycle but the write is still refused.
        drive(1'b0, 1'b1, word_t'(515), 1'b1);
        check("full s_ready", 64'(s_ready), 64'd0);
        check("full m_data", m_data, 64'd0);
`ifndef SDP_FIFO_BYPASS_EN
        check("full rd_addr", 64'(ram_rd_addr), 64'd3);
`endif
        drive(1'b0, 1'b1, word_t'(515), 1'b0);
        check("freed s_ready", 64'(s_ready), 64'd1);
        check("freed wr_en", 64'(ram_wr_en), 64'd1);
`ifndef SDP_FIFO_BYPASS_EN
        check("freed wr_addr", 64'(ram_wr_addr), 64'd3);
`endif

        exp_w = 1; errs = 0;
        for (int c = 0; c < 900 && exp_w < 516; c++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            if (m_valid) begin
                if (m_data !== word_t'(exp_w)) errs++;
                exp_w++;
            end
        end
        check("drain count", 64'(exp_w), 64'd516);
        check("drain order errors", 64'(errs), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b0);
        check("drain level", 64'(level), 64'd0);
        check("drain m_valid", 64'(m_valid), 64'd0);

        // Single-word latency from an empty FIFO.
        drive(1'b0, 1'b1, 64'hDEADBEEF_00000001, 1'b0);
        check("lat s_ready", 64'(s_ready), 64'd1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            if (m_valid) begin
                lat = k;
                break;
            end
        end
`ifdef SDP_FIFO_BYPASS_EN
        check("latency", 64'(lat), 64'd1);
`else
        check("latency", 64'(lat), 64'd4);
`endif
        check("lat m_data", m_data, 64'hDEADBEEF_00000001);
        drive(1'b0, 1'b0, '0, 1'b1);

        // Continuous streaming across several address wraps.
        sent = 0; rcvd = 0; errs = 0; gaps = 0;
        for (int c = 0; c < 2100 && rcvd < 2000; c++) begin
            drive(1'b0, sent < 2000, pat(sent), 1'b1);
            if (s_valid && s_ready) sent++;
            if (m_valid) begin
                if (m_data !== pat(rcvd)) errs++;
                rcvd++;
            end else if (rcvd > 0) begin
                gaps++;
            end
        end
        check("stream count", 64'(rcvd), 64'd2000);
        check("stream data errors", 64'(errs), 64'd0);
        check("stream gaps", 64'(gaps), 64'd0);

        // Random back-pressure with a level model.
        sent = 0; rcvd = 0; errs = 0; lvl_err = 0; lvl_max = 0;
        for (int c = 0; c < 60000 && rcvd < 10000; c++) begin
            sv_r = (sent < 10000) && ($urandom_range(99) < 70);
            mr_r = $urandom_range(99) < 30;
            drive(1'b0, sv_r, pat(sent + 5000), mr_r);
            if (int'(level) != sent - rcvd) lvl_err++;
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (s_valid && s_ready) sent++;
            if (m_valid && m_ready) begin
                if (m_data !== pat(rcvd + 5000)) errs++;
                rcvd++;
            end
        end
        check("random count", 64'(rcvd), 64'd10000);
        check("random data errors", 64'(errs), 64'd0);
        check("random level errors", 64'(lvl_err), 64'd0);
        check("random level bound", 64'(lvl_max <= 515), 64'd1);

        // Reset with 100 words stored and two reads in flight.
        drive(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, pat(20000 + i), 1'b0);
        repeat (4) drive(1'b0, 1'b0, '0, 1'b0);
        check("pre-reset level", 64'(level), 64'd100);
        repeat (2) drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b1, 1'b1, pat(999), 1'b0);
        check("rst s_ready", 64'(s_ready), 64'd0);
        drive(1'b0, 1'b0, '0, 1'b0);
        check("post-rst level", 64'(level), 64'd0);
        check("post-rst m_valid", 64'(m_valid), 64'd0);
        drive(1'b0, 1'b1, pat(777), 1'b0);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            if (m_valid) begin
                lat = k;
                check("post-rst first word", m_data, pat(777));
                break;
            end
        end
        check("post-rst word seen", 64'(lat > 0), 64'd1);
        drive(1'b0, 1'b0, '0, 1'b0);
        check("post-rst final level", 64'(level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
